// File: rtl/uart_cfg_arbiter.sv
// uart_cfg_arbiter
//
// Shares the single register port of uart_regs between two requesters:
//   - a host pass-through for single register reads and writes, and
//   - an autonomous configuration sequencer that programs DLL/DLM (with DLAB
//     set), then LCR, FCR, MCR and IER, as seven back-to-back writes.
// A configuration request always wins arbitration in IDLE. A request that
// arrives while a host access is in flight is remembered in 'pend' and run in
// the next IDLE cycle. The host is stalled while a sequence runs.
//
// Ports:
//   clk, wb_rst_i        clock, asynchronous active-high reset
//   cfg_start            single-cycle request to run the configuration sequence
//   cfg_dl/lcr/fcr/      configuration values, sampled when the request is taken
//   mcr/ier
//   cfg_busy             request accepted, pending or running
//   cfg_done             one-cycle pulse when the sequence completes
//   h_req/h_we/h_addr/   host access request (held until h_ack)
//   h_wdat
//   h_ack, h_rdat        host completion pulse and last read data
//   reg_addr/reg_wdat/   register port towards uart_regs (strobes are
//   reg_we/reg_re        single-cycle pulses)
//   reg_rdat             registered read data from uart_regs
//
// Every output is a flop. The next-state logic runs one step ahead, and the
// outputs that belong to a state are registered on the same edge that enters
// that state, so the strobes line up with the state they belong to.

module uart_cfg_arbiter #(
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              wb_rst_i,
    input  logic              cfg_start,
    input  logic [15:0]       cfg_dl,
    input  logic [7:0]        cfg_lcr,
    input  logic [1:0]        cfg_fcr,
    input  logic [4:0]        cfg_mcr,
    input  logic [3:0]        cfg_ier,
    output logic              cfg_busy,
    output logic              cfg_done,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [7:0]        h_wdat,
    output logic              h_ack,
    output logic [7:0]        h_rdat,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdat,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdat
);

    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] H_WR   = 4'd1;
    localparam logic [3:0] H_RD   = 4'd2;
    localparam logic [3:0] H_RDW  = 4'd3;
    localparam logic [3:0] H_RDC  = 4'd4;
    localparam logic [3:0] C_DLAB = 4'd5;
    localparam logic [3:0] C_DLL  = 4'd6;
    localparam logic [3:0] C_DLM  = 4'd7;
    localparam logic [3:0] C_LCR  = 4'd8;
    localparam logic [3:0] C_FCR  = 4'd9;
    localparam logic [3:0] C_MCR  = 4'd10;
    localparam logic [3:0] C_IER  = 4'd11;
    localparam logic [3:0] C_DONE = 4'd12;

    // uart_regs register addresses used by the sequencer
    localparam logic [ADDR_W-1:0] ADDR_TR = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_IE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_FC = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] ADDR_LC = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] ADDR_MC = ADDR_W'(4);

    logic [3:0]  state, state_nxt;
    logic        pend, pend_nxt;
    logic        host_busy;
    logic        capture;

    // Shadow copies of the configuration. sh_lcr keeps bit 7 forced to zero
    // so the DLAB bit only ever comes from the sequencer.
    logic [15:0] sh_dl, dl_nxt;
    logic [7:0]  sh_lcr, lcr_nxt;
    logic [1:0]  sh_fcr, fcr_nxt;
    logic [4:0]  sh_mcr, mcr_nxt;
    logic [3:0]  sh_ier, ier_nxt;

    logic              we_nxt, re_nxt, ack_nxt, done_nxt, busy_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [7:0]        wdat_nxt;

    // Next-state and arbitration. A configuration request seen during a host
    // access is parked in pend; one seen during a running sequence is dropped.
    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        host_busy = (state == H_WR) || (state == H_RD) ||
                    (state == H_RDW) || (state == H_RDC);
        capture   = cfg_start && ((state == IDLE) || host_busy);

        case (state)
            IDLE: begin
                if (cfg_start || pend) begin
                    state_nxt = C_DLAB;
                    pend_nxt  = 1'b0;
                end else if (h_req) begin
                    state_nxt = h_we ? H_WR : H_RD;
                end
            end
            H_WR:    state_nxt = IDLE;
            H_RD:    state_nxt = H_RDW;
            H_RDW:   state_nxt = H_RDC;
            H_RDC:   state_nxt = IDLE;
            C_DLAB:  state_nxt = C_DLL;
            C_DLL:   state_nxt = C_DLM;
            C_DLM:   state_nxt = C_LCR;
            C_LCR:   state_nxt = C_FCR;
            C_FCR:   state_nxt = C_MCR;
            C_MCR:   state_nxt = C_IER;
            C_IER:   state_nxt = C_DONE;
            C_DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (host_busy && cfg_start) begin
            pend_nxt = 1'b1;
        end

        dl_nxt  = capture ? cfg_dl                 : sh_dl;
        lcr_nxt = capture ? (cfg_lcr & 8'h7F)      : sh_lcr;
        fcr_nxt = capture ? cfg_fcr                : sh_fcr;
        mcr_nxt = capture ? cfg_mcr                : sh_mcr;
        ier_nxt = capture ? cfg_ier                : sh_ier;
    end

    // Output values for the state being entered. Address and data keep their
    // previous values unless the new state issues an access.
    always_comb begin
        we_nxt   = 1'b0;
        re_nxt   = 1'b0;
        ack_nxt  = 1'b0;
        done_nxt = 1'b0;
        addr_nxt = reg_addr;
        wdat_nxt = reg_wdat;

        case (state_nxt)
            H_WR: begin
                we_nxt   = 1'b1;
                ack_nxt  = 1'b1;
                addr_nxt = h_addr;
                wdat_nxt = h_wdat;
            end
            H_RD: begin
                re_nxt   = 1'b1;
                addr_nxt = h_addr;
            end
            H_RDC:  ack_nxt = 1'b1;
            C_DLAB: begin
                we_nxt   = 1'b1;
                addr_nxt = ADDR_LC;
                wdat_nxt = lcr_nxt | 8'h80;
            end
            C_DLL: begin
                we_nxt   = 1'b1;
                addr_nxt = ADDR_TR;
                wdat_nxt = dl_nxt[7:0];
            end
            C_DLM: begin
                we_nxt   = 1'b1;
                addr_nxt = ADDR_IE;
                wdat_nxt = dl_nxt[15:8];
            end
            C_LCR: begin
                we_nxt   = 1'b1;
                addr_nxt = ADDR_LC;
                wdat_nxt = lcr_nxt;
            end
            C_FCR: begin
                // Bits 2:1 reset both FIFOs while the trigger level is set.
                we_nxt   = 1'b1;
                addr_nxt = ADDR_FC;
                wdat_nxt = {fcr_nxt, 6'b000110};
            end
            C_MCR: begin
                we_nxt   = 1'b1;
                addr_nxt = ADDR_MC;
                wdat_nxt = {3'b000, mcr_nxt};
            end
            C_IER: begin
                we_nxt   = 1'b1;
                addr_nxt = ADDR_IE;
                wdat_nxt = {4'b0000, ier_nxt};
            end
            C_DONE: done_nxt = 1'b1;
            default: ;
        endcase

        busy_nxt = pend_nxt || ((state_nxt >= C_DLAB) && (state_nxt <= C_IER));
    end

    // State, shadow registers and all registered outputs. h_rdat captures the
    // read data in H_RDW, the cycle after reg_re, because uart_regs registers
    // its read data.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            pend     <= 1'b0;
            sh_dl    <= '0;
            sh_lcr   <= '0;
            sh_fcr   <= '0;
            sh_mcr   <= '0;
            sh_ier   <= '0;
            reg_we   <= 1'b0;
            reg_re   <= 1'b0;
            reg_addr <= '0;
            reg_wdat <= '0;
            h_ack    <= 1'b0;
            h_rdat   <= '0;
            cfg_done <= 1'b0;
            cfg_busy <= 1'b0;
        end else begin
            state    <= state_nxt;
            pend     <= pend_nxt;
            sh_dl    <= dl_nxt;
            sh_lcr   <= lcr_nxt;
            sh_fcr   <= fcr_nxt;
            sh_mcr   <= mcr_nxt;
            sh_ier   <= ier_nxt;
            reg_we   <= we_nxt;
            reg_re   <= re_nxt;
            reg_addr <= addr_nxt;
            reg_wdat <= wdat_nxt;
            h_ack    <= ack_nxt;
            cfg_done <= done_nxt;
            cfg_busy <= busy_nxt;
            if (state == H_RDW) begin
                h_rdat <= reg_rdat;
            end
        end
    end

endmodule
